// File: rtl/konnect_slave_n.sv
// rtl/konnect_slave_n.sv - Konnect bus slave: synchronised capture, atomic output commit, watchdog
module konnect_slave_n #(
  parameter logic [7:0] ADDR        = 8'h0F,
  parameter int         N_OUT       = 2,
  parameter int         N_IN        = 3,
  parameter logic [7:0] EOC         = 8'hA5,
  parameter int         WDOG_CYCLES = 6650000
) (
  input  logic                 clk,
  input  logic                 kreset,
  input  logic                 k_clk,
  input  logic                 start_in,
  input  logic [7:0]           kdata_in,
  output logic [7:0]           kdata_out,
  output logic                 kdata_oe,
  input  logic [8*N_IN-1:0]    k_in,
  output logic [8*N_OUT-1:0]   k_out,
  output logic                 xfer_done,
  output logic                 wdog_trip
);

  localparam int LAST = N_OUT + N_IN + 2;
  localparam int SW   = $clog2(LAST + 1);
  localparam int SHW  = (N_OUT > 1) ? 8 * (N_OUT - 1) : 8;
  localparam int CW   = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;

  localparam logic [SW-1:0] S_LAST   = SW'(LAST);
  localparam logic [SW-1:0] S_COMMIT = SW'(N_OUT);
  localparam logic [SW-1:0] S_EOC    = SW'(N_OUT + N_IN);
  localparam logic [SW-1:0] S_OE_LO  = SW'(N_OUT + 1);
  localparam logic [SW-1:0] S_OE_HI  = SW'(N_OUT + N_IN + 1);
  localparam logic [CW-1:0] W_MAX    = CW'(WDOG_CYCLES);

  logic [2:0]         kclk_sync_q, start_sync_q;
  logic               kclk_rise, kclk_fall, start_rise, start_fall;

  logic               sm_en_q, sm_en_d;
  logic [SW-1:0]      state_q, state_d;
  logic [SHW-1:0]     shadow_q, shadow_d;
  logic [8*N_OUT-1:0] k_out_q, k_out_d;
  logic [7:0]         kdata_out_q, kdata_out_d;
  logic               xfer_done_q, xfer_done_d;
  logic               wdog_trip_q, wdog_trip_d;
  logic [CW-1:0]      wdog_q, wdog_d;

  // Two synchroniser flops per bus line, third flop keeps history for edge detection
  always_ff @(posedge clk or negedge kreset) begin
    if (!kreset) begin
      kclk_sync_q  <= '0;
      start_sync_q <= '0;
    end else begin
      kclk_sync_q  <= {kclk_sync_q[1:0], k_clk};
      start_sync_q <= {start_sync_q[1:0], start_in};
    end
  end

  assign kclk_rise  =  kclk_sync_q[1]  & ~kclk_sync_q[2];
  assign kclk_fall  = ~kclk_sync_q[1]  &  kclk_sync_q[2];
  assign start_rise =  start_sync_q[1] & ~start_sync_q[2];
  assign start_fall = ~start_sync_q[1] &  start_sync_q[2];

  // Next-state: watchdog first so that a commit in the same clk overrides a trip
  always_comb begin
    sm_en_d     = sm_en_q;
    state_d     = state_q;
    shadow_d    = shadow_q;
    k_out_d     = k_out_q;
    kdata_out_d = kdata_out_q;
    xfer_done_d = 1'b0;
    wdog_trip_d = wdog_trip_q;
    wdog_d      = wdog_q;

    if (WDOG_CYCLES > 0) begin
      if (wdog_q != W_MAX) begin
        wdog_d = wdog_q + CW'(1);
        if (wdog_d == W_MAX) begin
          k_out_d     = '0;
          wdog_trip_d = 1'b1;
        end
      end
    end

    if (start_rise) begin
      state_d = '0;
    end else if (start_fall) begin
      sm_en_d = (kdata_in == ADDR);
    end else if (kclk_rise) begin
      if (sm_en_q && state_q != S_LAST) state_d = state_q + SW'(1);
    end else if (kclk_fall && sm_en_q) begin
      // Early write bytes park in the shadow until the final byte arrives
      for (int j = 0; j < SHW / 8; j++) begin
        if ((j + 1) < N_OUT && state_q == SW'(j + 1)) shadow_d[8*j +: 8] = kdata_in;
      end
      if (state_q == S_COMMIT) begin
        for (int j = 0; j < N_OUT - 1; j++) k_out_d[8*j +: 8] = shadow_q[8*j +: 8];
        k_out_d[8*(N_OUT-1) +: 8] = kdata_in;
        xfer_done_d = 1'b1;
        wdog_d      = '0;
        wdog_trip_d = 1'b0;
      end
      kdata_out_d = 8'h00;
      for (int i = 0; i < N_IN; i++) begin
        if (state_q == SW'(N_OUT + i)) kdata_out_d = k_in[8*i +: 8];
      end
      if (state_q == S_EOC) kdata_out_d = EOC;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge kreset) begin
    if (!kreset) begin
      sm_en_q     <= 1'b0;
      state_q     <= '0;
      shadow_q    <= '0;
      k_out_q     <= '0;
      kdata_out_q <= 8'h00;
      xfer_done_q <= 1'b0;
      wdog_trip_q <= 1'b0;
      wdog_q      <= '0;
    end else begin
      sm_en_q     <= sm_en_d;
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      k_out_q     <= k_out_d;
      kdata_out_q <= kdata_out_d;
      xfer_done_q <= xfer_done_d;
      wdog_trip_q <= wdog_trip_d;
      wdog_q      <= wdog_d;
    end
  end

  // Drive only while the host holds k_clk high in a read slot of our own frame
  assign kdata_oe  = k_clk & ~start_in & sm_en_q & (state_q >= S_OE_LO) & (state_q <= S_OE_HI);
  assign kdata_out = kdata_out_q;
  assign k_out     = k_out_q;
  assign xfer_done = xfer_done_q;
  assign wdog_trip = wdog_trip_q;

endmodule

// File: tb/tb_konnect_slave_n.sv
// tb/tb_konnect_slave_n.sv - directed frames against a frame-level model of the Konnect slave
module tb_konnect_slave_n;

  localparam int         N_OUT = 2;
  localparam int         N_IN  = 3;
  localparam int         W     = 100;
  localparam int         LAST  = N_OUT + N_IN + 2;
  localparam logic [7:0] ADDR  = 8'h0F;
  localparam logic [7:0] EOC   = 8'hA5;

  logic        clk = 1'b0;
  logic        kreset = 1'b0;
  logic        k_clk = 1'b0;
  logic        start_in = 1'b1;
  logic [7:0]  kdata_in = 8'h00;
  logic [7:0]  kdata_out;
  logic        kdata_oe;
  logic [23:0] k_in = 24'h112233;
  logic [15:0] k_out;
  logic        xfer_done;
  logic        wdog_trip;

  always #5 clk = ~clk;

  konnect_slave_n #(
    .ADDR(ADDR), .N_OUT(N_OUT), .N_IN(N_IN), .EOC(EOC), .WDOG_CYCLES(W)
  ) dut (
    .clk(clk), .kreset(kreset), .k_clk(k_clk), .start_in(start_in),
    .kdata_in(kdata_in), .kdata_out(kdata_out), .kdata_oe(kdata_oe),
    .k_in(k_in), .k_out(k_out), .xfer_done(xfer_done), .wdog_trip(wdog_trip)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int chg_cyc = 0;

  // Frame-level model
  logic        m_sm_en = 1'b0;
  int          m_state = 0;
  logic [7:0]  m_sh0 = 8'h00;
  logic [15:0] m_kout = 16'h0000;
  logic [7:0]  m_bus = 8'h00;
  int          m_commit_cyc = 0;
  logic        m_tripped;
  logic        m_oe;

  int          dut_xfers = 0;
  logic        oe_seen = 1'b0;
  logic [7:0]  reads[$];
  logic [7:0]  exp_rd[4];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare DUT against the model whenever the inputs have been still long enough to settle
  always @(negedge clk) begin
    if (kreset) begin
      if (xfer_done) dut_xfers++;
      if (kdata_oe) oe_seen = 1'b1;
      if (cyc - chg_cyc >= 3) begin
        m_tripped = (cyc >= m_commit_cyc + W);
        m_oe = k_clk & ~start_in & m_sm_en & (m_state >= N_OUT + 1) & (m_state <= N_OUT + N_IN + 1);
        check("k_out", k_out, m_tripped ? 16'h0000 : m_kout);
        check("wdog_trip", wdog_trip, m_tripped);
        check("kdata_out", kdata_out, m_bus);
        check("kdata_oe", kdata_oe, m_oe);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_fall(input logic [7:0] d);
    if (m_state >= 1 && m_state < N_OUT) m_sh0 = d;
    if (m_state == N_OUT) begin
      m_kout = {d, m_sh0};
      m_commit_cyc = cyc + 3;
    end
    if (m_state >= N_OUT && m_state < N_OUT + N_IN) m_bus = k_in[8*(m_state-N_OUT) +: 8];
    else if (m_state == N_OUT + N_IN) m_bus = EOC;
    else m_bus = 8'h00;
  endtask

  task automatic drive_start(input logic v, input logic [7:0] d);
    chg_cyc = cyc;
    start_in = v;
    kdata_in = d;
    if (v) m_state = 0;
    else m_sm_en = (d == ADDR);
    step(4);
  endtask

  task automatic drive_kclk(input logic v, input logic [7:0] d);
    chg_cyc = cyc;
    k_clk = v;
    kdata_in = d;
    if (v) begin
      if (m_sm_en && m_state < LAST) m_state++;
    end else if (m_sm_en) begin
      model_fall(d);
    end
    step(4);
    if (v && kdata_oe) reads.push_back(kdata_out);
  endtask

  task automatic frame(input logic [7:0] addr, input logic [7:0] b0, input logic [7:0] b1, input int npulses);
    reads.delete();
    dut_xfers = 0;
    oe_seen = 1'b0;
    drive_start(1'b0, addr);
    for (int i = 0; i < npulses; i++) begin
      drive_kclk(1'b1, (i == 0) ? b0 : (i == 1) ? b1 : 8'h00);
      drive_kclk(1'b0, (i == 0) ? b0 : (i == 1) ? b1 : 8'h00);
    end
    drive_start(1'b1, 8'h00);
  endtask

  task automatic check_frame(input logic [15:0] kout_exp, input int nreads, input int nxfer);
    check("frame_k_out", k_out, kout_exp);
    check("frame_xfers", dut_xfers, nxfer);
    check("frame_rd_cnt", reads.size(), nreads);
    for (int i = 0; i < nreads && i < 4; i++)
      check("frame_rd_byte", (i < reads.size()) ? reads[i] : 8'hxx, exp_rd[i]);
  endtask

  task automatic check_reset_outputs();
    check("rst_k_out", k_out, 16'h0000);
    check("rst_kdata_out", kdata_out, 8'h00);
    check("rst_kdata_oe", kdata_oe, 1'b0);
    check("rst_xfer_done", xfer_done, 1'b0);
    check("rst_wdog_trip", wdog_trip, 1'b0);
  endtask

  task automatic release_reset();
    chg_cyc = cyc;
    kreset = 1'b1;
    m_commit_cyc = cyc;
    step(4);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int target;
    exp_rd[0] = 8'h33; exp_rd[1] = 8'h22; exp_rd[2] = 8'h11; exp_rd[3] = 8'hA5;
    step(3);
    check_reset_outputs();
    release_reset();

    // Addressed frame
    frame(ADDR, 8'h3C, 8'hC3, LAST);
    check_frame(16'hC33C, 4, 1);
    check("post_frame_bus", kdata_out, 8'h00);

    // Abort after first byte leaves k_out alone
    frame(ADDR, 8'h55, 8'h00, 1);
    check_frame(16'hC33C, 0, 0);

    // Next full frame overwrites the stale shadow byte
    frame(ADDR, 8'h01, 8'h02, LAST);
    check_frame(16'h0201, 4, 1);

    // Wrong address: nothing moves
    frame(8'h0E, 8'h3C, 8'hC3, 4);
    check_frame(16'h0201, 0, 0);
    check("wrong_addr_oe", oe_seen, 1'b0);

    // Watchdog trips exactly W clks after the last commit
    target = m_commit_cyc + W - 1;
    for (int i = 0; i < 300 && cyc < target; i++) step(1);
    if (cyc != target) begin
      checks++;
      failures++;
      $display("FAIL wdog_wait: cycle=%0d expected=%0d", cyc, target);
    end
    check("wdog_before_k_out", k_out, 16'h0201);
    check("wdog_before_trip", wdog_trip, 1'b0);
    step(1);
    check("wdog_after_k_out", k_out, 16'h0000);
    check("wdog_after_trip", wdog_trip, 1'b1);
    frame(ADDR, 8'hEF, 8'hBE, LAST);
    check_frame(16'hBEEF, 4, 1);
    check("wdog_cleared", wdog_trip, 1'b0);

    // Overrun: extra k_clk pulses past LAST
    frame(ADDR, 8'h77, 8'h66, 10);
    check_frame(16'h6677, 4, 1);
    check("overrun_bus", kdata_out, 8'h00);

    // Async reset mid-frame
    drive_start(1'b0, ADDR);
    drive_kclk(1'b1, 8'h99);
    drive_kclk(1'b0, 8'h99);
    #2;
    kreset = 1'b0;
    m_kout = 16'h0000; m_bus = 8'h00; m_state = 0; m_sm_en = 1'b0; m_sh0 = 8'h00;
    #1;
    check_reset_outputs();
    step(2);
    release_reset();
    drive_start(1'b1, 8'h00);
    frame(ADDR, 8'h44, 8'h33, LAST);
    check_frame(16'h3344, 4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/konnect_slave_n.md
Name: konnect_slave_n

Overview:
- Parametrised Konnect-bus slave for the KFLOP JP6 8-bit bus; successor to the fixed 16-out/24-in slave in the Kanalog/Konnect buffer FPGA.
- Synchronises k_clk/start_in, decodes the board address, captures N_OUT output bytes, and returns N_IN input bytes followed by an end-of-cycle marker.
- New behaviour: outputs commit atomically on the last output byte, a watchdog clears outputs when the host stops talking, and the state counter saturates instead of wrapping.
- Tristate buffers (BB) stay in the top level; this block exports kdata_out and kdata_oe.

Parameters:
- ADDR, 8'h0F, board address compared at start_in falling edge.
- N_OUT, 2, output bytes written by host (1..8).
- N_IN, 3, input bytes returned to host (1..8).
- EOC, 8'hA5, end-of-cycle byte driven after the last input byte.
- WDOG_CYCLES, 6650000, clk cycles without a commit before outputs clear (0 = watchdog disabled).

Ports:
- clk  in  1  FPGA clock (66.5 MHz).
- kreset  in  1  asynchronous active-low reset.
- k_clk  in  1  raw Konnect bus clock.
- start_in  in  1  raw Konnect start strobe.
- kdata_in  in  8  bus data from the BB O pins.
- kdata_out  out  8  bus data to the BB I pins.
- kdata_oe  out  1  active-high drive enable (top level inverts it for BB T).
- k_in  in  8*N_IN  board inputs; byte i = k_in[8i+7:8i].
- k_out  out  8*N_OUT  board outputs; byte j = k_out[8j+7:8j].
- xfer_done  out  1  one-clk pulse on commit.
- wdog_trip  out  1  high while the watchdog has cleared the outputs.

Behaviour:
- Reset (kreset low, async): k_out=0, shadow=0, kdata_out=0, sm_en=0, state=0, xfer_done=0, wdog_trip=0, wdog counter=0.
- Sync: k_clk and start_in each pass through 2 flops, then an edge detector.
  - Rise/fall pulses are 1 clk wide and appear 3 clks after the raw edge.
- Event priority per clk: start_rise > start_fall > kclk_rise > kclk_fall. Only one event is acted on per clk.
- start_rise: state <= 0; sm_en unchanged.
- start_fall: sm_en <= (kdata_in == ADDR). State stays 0.
- kclk_rise with sm_en: state <= state+1, saturating at LAST = N_OUT+N_IN+2.
- kclk_fall with sm_en, by state s:
  - 1 <= s < N_OUT: shadow byte s-1 <= kdata_in.
  - s == N_OUT: k_out <= {kdata_in, shadow bytes 0..N_OUT-2}; xfer_done pulses; wdog counter clears; wdog_trip clears.
  - N_OUT <= s < N_OUT+N_IN: kdata_out <= k_in byte (s-N_OUT). At s == N_OUT this happens in the same clk as the commit.
  - s == N_OUT+N_IN: kdata_out <= EOC.
  - otherwise (incl. s == 0): kdata_out <= 8'h00.
- kdata_oe (combinational on raw pins) = k_clk & ~start_in & sm_en & (N_OUT+1 <= state <= N_OUT+N_IN+1).
- Atomicity: an aborted frame (start_rise before s == N_OUT falls) never changes k_out. Partial shadow data is discarded and overwritten by the next frame.
- Non-matching address: sm_en=0, so no state advance, no capture, oe=0. This holds until the next start_fall.
- Watchdog (WDOG_CYCLES > 0):
  - Counter increments every clk and saturates at WDOG_CYCLES.
  - On reaching WDOG_CYCLES: k_out <= 0, wdog_trip <= 1.
  - The next commit clears the counter and wdog_trip.
  - A commit in the same clk as the trip wins: k_out takes the new data, wdog_trip stays 0.
- Extra k_clk pulses past LAST: state holds at LAST, kdata_out=0, oe=0.
- Reset mid-frame: everything returns to its reset values immediately. k_out is not restored.

Test Plan:
- Addressed frame: start_in 1->0 with kdata_in=0x0F; write 0x3C, 0xC3; k_in=0x112233 -> k_out=0xC33C; bus reads 0x33, 0x22, 0x11, 0xA5; xfer_done pulses exactly once.
- Wrong address 0x0E, same frame -> k_out unchanged, kdata_oe never asserted, xfer_done stays 0.
- Abort: start_rise after the first byte (0x55) only -> k_out holds its prior 0xC33C; the next full frame writing 0x01, 0x02 -> k_out=0x0201.
- Watchdog: WDOG_CYCLES=100, commit then idle 100 clks -> k_out=0, wdog_trip=1 at clk 100; next commit 0xBEEF -> k_out=0xBEEF, wdog_trip=0.
- Overrun: 10 k_clk pulses in one frame -> state saturates at 7, bus returns 0x00 with oe low, no second commit.
- Async reset asserted mid-frame (after byte 0) -> all outputs 0 within the same clk; a subsequent full frame works normally.
